// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for hazard control:
// forwarding codes, mult/div FSM states, defaults.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_SRC = 2'b00;
  localparam logic [1:0] FWD_ALU = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MD_LATENCY_DEF = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic [1:0] sel;
    sel = FWD_SRC;
    if (wb_we && wb_rd != 5'd0 && wb_rd == src)
      sel = FWD_MEM;
    if (mem_we && mem_rd != 5'd0 && mem_rd == src)
      sel = FWD_ALU;
    return sel;
  endfunction

endpackage

// File: rtl/md_timer.sv
// Mult/div countdown: loaded on start,
// counts down while busy, saturates at zero.
module md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  output logic cnt_zero
);

  localparam logic [5:0] LOAD = 6'(LATENCY - 1);

  logic [5:0] cnt;

  assign cnt_zero = (cnt == 6'd0);

  // load on start, decrement while busy, hold at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 6'd0;
    else if (start)
      cnt <= LOAD;
    else if (busy && !cnt_zero)
      cnt <= cnt - 6'd1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use
// and mult/div stalls, branch flush.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_md_start,
  input  logic       id_md_use,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  input  logic       branch_taken,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       risk_sig,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       flush_ifid,
  output logic       md_busy
);

  md_state_t state;
  md_state_t state_nxt;

  logic load_use;
  logic md_stall;
  logic md_start;
  logic cnt_zero;

  assign load_use = ex_memread && ex_rd != 5'd0 &&
                    (ex_rd == id_rs ||
                     (id_uses_rt && ex_rd == id_rt));

  assign md_busy  = (state == MD_BUSY);
  assign md_stall = md_busy && (id_md_use || id_md_start);
  assign md_start = id_md_start && !md_busy &&
                    !load_use && !branch_taken;

  md_timer #(
    .LATENCY(MD_LATENCY)
  ) u_md_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (md_start),
    .busy    (md_busy),
    .cnt_zero(cnt_zero)
  );

  // mult/div state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= MD_IDLE;
    else
      state <= state_nxt;
  end

  // mult/div next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      MD_IDLE: if (md_start) state_nxt = MD_BUSY;
      MD_BUSY: if (cnt_zero) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // forwarding selects, held at register source in reset
  always_comb begin
    fwd_a = FWD_SRC;
    fwd_b = FWD_SRC;
    if (rst_n) begin
      fwd_a = fwd_sel(ex_rs, mem_rd, mem_regwrite,
                      wb_rd, wb_regwrite);
      fwd_b = fwd_sel(ex_rt, mem_rd, mem_regwrite,
                      wb_rd, wb_regwrite);
    end
  end

  // pipeline control: reset, then flush, then stalls
  always_comb begin
    risk_sig   = 1'b0;
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    flush_ifid = 1'b0;
    if (!rst_n) begin
      risk_sig = 1'b1;
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
    end else if (branch_taken) begin
      risk_sig   = 1'b1;
      flush_ifid = 1'b1;
    end else if (load_use || md_stall) begin
      risk_sig = 1'b1;
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a
// behavioural model, plus directed literal checks.
module tb_hazard_ctrl;

  localparam int MDL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rt, id_md_start, id_md_use;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_memread;
  logic [4:0] mem_rd, wb_rd;
  logic       mem_regwrite, wb_regwrite;
  logic       branch_taken;
  logic [1:0] fwd_a, fwd_b;
  logic       risk_sig, pc_we, ifid_we;
  logic       flush_ifid, md_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_left = 0;
  bit cmp_en = 1'b0;

  hazard_ctrl #(.MD_LATENCY(MDL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .id_md_start (id_md_start),
    .id_md_use   (id_md_use),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .mem_rd      (mem_rd),
    .mem_regwrite(mem_regwrite),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .branch_taken(branch_taken),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .risk_sig    (risk_sig),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .flush_ifid  (flush_ifid),
    .md_busy     (md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int m_fwd(input logic [4:0] s);
    if (mem_regwrite && mem_rd != 0 && mem_rd == s)
      return 1;
    if (wb_regwrite && wb_rd != 0 && wb_rd == s)
      return 2;
    return 0;
  endfunction

  function automatic bit m_lu();
    return ex_memread && ex_rd != 0 &&
           (ex_rd == id_rs ||
            (id_uses_rt && ex_rd == id_rt));
  endfunction

  // model: cycles left in the current mult/div op
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_left = 0;
    else if (busy_left > 0)
      busy_left = busy_left - 1;
    else if (id_md_start && !m_lu() && !branch_taken)
      busy_left = MDL;
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      int ea, eb, er, ep, ei, ef, em;
      bit stall;
      em = (busy_left > 0) ? 1 : 0;
      stall = m_lu() ||
              (em == 1 && (id_md_use || id_md_start));
      if (!rst_n) begin
        ea = 0; eb = 0; er = 1; ep = 0; ei = 0;
        ef = 0; em = 0;
      end else begin
        ea = m_fwd(ex_rs);
        eb = m_fwd(ex_rt);
        ef = branch_taken ? 1 : 0;
        er = (branch_taken || stall) ? 1 : 0;
        ep = (branch_taken || !stall) ? 1 : 0;
        ei = ep;
      end
      chk("m_fwd_a", fwd_a, ea);
      chk("m_fwd_b", fwd_b, eb);
      chk("m_risk", risk_sig, er);
      chk("m_pc_we", pc_we, ep);
      chk("m_ifid_we", ifid_we, ei);
      chk("m_flush", flush_ifid, ef);
      chk("m_md_busy", md_busy, em);
    end
  end

  task automatic quiet();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    id_md_start = 0; id_md_use = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0;
    wb_rd = 0; wb_regwrite = 0;
    branch_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nb, np;
    quiet();
    rst_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_risk", risk_sig, 1);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_ifid_we", ifid_we, 0);
    chk("rst_md_busy", md_busy, 0);
    step();
    rst_n = 1'b1;
    step();

    // forwarding priority and x0 exclusion
    ex_rs = 5; mem_rd = 5; mem_regwrite = 1;
    wb_rd = 5; wb_regwrite = 1;
    @(negedge clk);
    chk("fwd_mem_prio", fwd_a, 1);
    step();
    mem_rd = 0;
    @(negedge clk);
    chk("fwd_wb", fwd_a, 2);
    step();
    quiet();

    // load-use stall for one cycle
    ex_memread = 1; ex_rd = 8; id_rt = 8; id_uses_rt = 1;
    @(negedge clk);
    chk("lu_risk", risk_sig, 1);
    chk("lu_pc_we", pc_we, 0);
    step();
    ex_memread = 0;
    @(negedge clk);
    chk("lu_release", pc_we, 1);
    step();
    quiet();

    // mult/div occupancy with HI/LO reader waiting
    id_md_start = 1; id_md_use = 1;
    nb = 0; np = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nb += md_busy;
      np += !pc_we;
      step();
      id_md_start = 0;
    end
    chk("md_busy_cycles", nb, MDL);
    chk("md_stall_cycles", np, MDL);
    quiet();

    // branch overrides load-use
    ex_memread = 1; ex_rd = 8; id_rs = 8;
    branch_taken = 1;
    @(negedge clk);
    chk("br_flush", flush_ifid, 1);
    chk("br_pc_we", pc_we, 1);
    chk("br_risk", risk_sig, 1);
    step();
    quiet();

    // reset in the middle of a mult/div op
    id_md_start = 1;
    step();
    id_md_start = 0;
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_busy", md_busy, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", md_busy, 0);
    chk("post_rst_pc_we", pc_we, 1);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      id_md_start = ($urandom_range(0, 9) == 0);
      id_md_use = ($urandom_range(0, 4) == 0);
      ex_rs = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_memread = ($urandom_range(0, 3) == 0);
      mem_rd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3));
      wb_regwrite = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    quiet();
    step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
